door_sequencer_ctrl: RTL and testbench
======================================

// Module: door_sequencer_ctrl
// PURPOSE
//  Sequencer in front of the door FSM: turns user commands into one-cycle key_up/key_down
//  pulses and watches sense_up/sense_down. Adds a travel-timeout watchdog, obstacle reopen
//  and optional auto-close. Shares rst_n/clk2m with the door FSM.
// PARAMETERS
//  HOLD_CYC    10_000_000  cycles door stays open before auto-close (5 s @ 2 MHz)
//  TRAVEL_CYC  20_000_000  max cycles from key pulse to end sensor before FAULT (10 s)
//  CNT_W       25          timer width; must satisfy 2**CNT_W > max(HOLD_CYC,TRAVEL_CYC)
// PORTS
//  clk2m       in   1  system clock, 2 MHz
//  rst_n       in   1  reset, asynchronous, active-low
//  cmd_open    in   1  open request, single-cycle pulse, synchronous to clk2m
//  cmd_close   in   1  close request, single-cycle pulse
//  obstacle    in   1  light-barrier level, 1 = blocked
//  fault_clr   in   1  leaves FAULT, single-cycle pulse
//  sense_up    in   1  door fully open (also wired to the door FSM)
//  sense_down  in   1  door fully closed (also wired to the door FSM)
//  key_up      out  1  to door FSM key_up, registered
//  key_down    out  1  to door FSM key_down, registered
//  door_open   out  1  1 in S_HOLD
//  busy        out  1  1 in S_WAIT_UP or S_WAIT_DOWN
//  fault       out  1  1 in S_FAULT
//  state_o     out  3  current state encoding, for debug
// BEHAVIOUR
//  Reset: state S_IDLE; all outputs 0; timer 0. Reset mid-travel aborts with no pulse issued.
//  All outputs are registered. A key pulse is high for exactly one clk2m cycle, in the cycle
//  after the triggering input.
//  States and transitions (priority top-down within each state):
//   S_IDLE: cmd_open -> pulse key_up, load TRAVEL, go S_WAIT_UP. Everything else ignored.
//   S_WAIT_UP: sense_up -> load HOLD, go S_HOLD. Timer expired -> S_FAULT.
//   S_HOLD:
//    - cmd_open -> reload HOLD.
//    - cmd_close, or auto-close expiry with obstacle=0 -> pulse key_down, load TRAVEL, go S_WAIT_DOWN.
//    - Expiry with obstacle=1 -> stay in S_HOLD, reload HOLD.
//   S_WAIT_DOWN:
//    - obstacle or cmd_open -> pulse key_up AND key_down in the same cycle (door FSM reopen),
//      load HOLD, go S_HOLD.
//    - sense_down -> S_CLOSED.
//    - Timer expired -> S_FAULT.
//   S_CLOSED: cmd_open -> pulse key_up, load TRAVEL, go S_WAIT_UP. cmd_close ignored.
//   S_FAULT: keys held 0. fault_clr -> S_IDLE. Only fault_clr or reset exits this state.
//  Global conditions:
//   - sense_up & sense_down both 1 in any non-FAULT state -> S_FAULT, highest priority.
//   - Simultaneous cmd_open & cmd_close: open wins.
//  Timer rules:
//   - Down-counter. "Load N" writes N-1; expiry = counter at 0 while in a timed state.
//   - Expiry therefore fires exactly N cycles after the load cycle.
//   - No wrap: the counter saturates at 0.
//  Unused encodings -> S_IDLE.
// CONFIGURATION
//  DOOR_AUTOCLOSE_EN defined: HOLD timer active as above.
//  Undefined: S_HOLD has no timeout and leaves only on cmd_close. door_open stays 1 until
//  then. cmd_open in S_HOLD has no effect. The HOLD_CYC parameter is ignored.
// STRUCTURE
//  door_pkg:
//   - enum logic [2:0] seq_state_t {S_IDLE, S_WAIT_UP, S_HOLD, S_WAIT_DOWN, S_CLOSED, S_FAULT}
//   - default HOLD_CYC / TRAVEL_CYC constants
//  Sub-module door_cycle_timer: CNT_W loadable down-counter with load, value and expired
//  outputs. One instance, shared by the HOLD and TRAVEL phases.
// TESTING  (bench uses HOLD_CYC=8, TRAVEL_CYC=16)
//  1. Reset, then cmd_open -> key_up=1 for 1 cycle, busy=1. sense_up after 5 cycles
//     -> door_open=1. With AUTOCLOSE, 8 cycles later -> key_down pulse, busy=1.
//  2. In S_WAIT_DOWN, obstacle=1 -> key_up=key_down=1 for exactly 1 cycle, door_open=1,
//     HOLD reloaded.
//  3. cmd_open with no sense_up -> fault=1 exactly 16 cycles after the key_up load,
//     keys stay 0. fault_clr -> state_o=S_IDLE.
//  4. cmd_open & cmd_close together in S_CLOSED -> key_up pulse only, key_down stays 0.
//  5. sense_up=sense_down=1 in S_HOLD -> fault=1 next cycle.
//  6. rst_n low while in S_WAIT_UP -> all outputs 0 immediately (asynchronous).
//     Release -> S_IDLE.
//     Without DOOR_AUTOCLOSE_EN: door_open held for 100 cycles until cmd_close.

Source files
------------

// File: rtl/door_pkg.sv
// Shared types and default timing constants for the door sequencer slice.
package door_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_UP   = 3'd1,
    S_HOLD      = 3'd2,
    S_WAIT_DOWN = 3'd3,
    S_CLOSED    = 3'd4,
    S_FAULT     = 3'd5
  } seq_state_t;

  localparam int unsigned HOLD_CYC_DEF   = 10_000_000;
  localparam int unsigned TRAVEL_CYC_DEF = 20_000_000;
  localparam int unsigned CNT_W_DEF      = 25;

  function automatic logic in_travel(seq_state_t s);
    return (s == S_WAIT_UP) || (s == S_WAIT_DOWN);
  endfunction

endpackage

// File: rtl/door_sequencer_ctrl_if.sv
// Signal bundle between the door sequencer (slave) and its environment (master).
interface door_sequencer_ctrl_if;

  // No valid/ready here: cmd_open, cmd_close, fault_clr are one-cycle pulses sampled
  // on every clk2m edge; obstacle and sense_* are levels; key_up/key_down are
  // one-cycle registered pulses issued the cycle after the triggering input.
  logic       cmd_open;
  logic       cmd_close;
  logic       obstacle;
  logic       fault_clr;
  logic       sense_up;
  logic       sense_down;
  logic       key_up;
  logic       key_down;
  logic       door_open;
  logic       busy;
  logic       fault;
  logic [2:0] state_o;

  modport master (
    output cmd_open, cmd_close, obstacle, fault_clr, sense_up, sense_down,
    input  key_up, key_down, door_open, busy, fault, state_o
  );

  modport slave (
    input  cmd_open, cmd_close, obstacle, fault_clr, sense_up, sense_down,
    output key_up, key_down, door_open, busy, fault, state_o
  );

endinterface

// File: rtl/door_cycle_timer.sv
// Loadable saturating down-counter shared by the HOLD and TRAVEL phases.
module door_cycle_timer #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk2m,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o   = cnt_q;
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/door_sequencer_ctrl.sv
// Door command sequencer with travel watchdog and obstacle reopen.
// Auto-close from S_HOLD is enabled by defining DOOR_AUTOCLOSE_EN.
module door_sequencer_ctrl
  import door_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned TRAVEL_CYC = TRAVEL_CYC_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk2m,
  input  logic                  rst_n,
  door_sequencer_ctrl_if.slave  door_if
);

  // Loading N-1 makes expiry land exactly N cycles after the load edge.
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYC - 1);

  seq_state_t       state_q, state_d;
  logic             key_up_q, key_up_d;
  logic             key_down_q, key_down_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_expired;
  logic [CNT_W-1:0] tmr_value_unused;

  door_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk2m      (clk2m),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value_unused),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    key_up_d     = 1'b0;
    key_down_d   = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = TRAVEL_LD;
    if ((state_q != S_FAULT) && door_if.sense_up && door_if.sense_down) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE, S_CLOSED: begin
          if (door_if.cmd_open) begin
            key_up_d = 1'b1;
            tmr_load = 1'b1;
            state_d  = S_WAIT_UP;
          end
        end
        S_WAIT_UP: begin
          if (door_if.sense_up) begin
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LD;
            state_d      = S_HOLD;
          end else if (tmr_expired) begin
            state_d = S_FAULT;
          end
        end
        S_HOLD: begin
`ifdef DOOR_AUTOCLOSE_EN
          if (door_if.cmd_open) begin
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LD;
          end else if (door_if.cmd_close || (tmr_expired && !door_if.obstacle)) begin
            key_down_d = 1'b1;
            tmr_load   = 1'b1;
            state_d    = S_WAIT_DOWN;
          end else if (tmr_expired) begin
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LD;
          end
`else
          if (door_if.cmd_close && !door_if.cmd_open) begin
            key_down_d = 1'b1;
            tmr_load   = 1'b1;
            state_d    = S_WAIT_DOWN;
          end
`endif
        end
        S_WAIT_DOWN: begin
          // Both keys together tell the door FSM to reverse.
          if (door_if.obstacle || door_if.cmd_open) begin
            key_up_d     = 1'b1;
            key_down_d   = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = HOLD_LD;
            state_d      = S_HOLD;
          end else if (door_if.sense_down) begin
            state_d = S_CLOSED;
          end else if (tmr_expired) begin
            state_d = S_FAULT;
          end
        end
        S_FAULT: begin
          if (door_if.fault_clr) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      key_up_q   <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_up_q   <= key_up_d;
      key_down_q <= key_down_d;
    end
  end

  assign door_if.key_up    = key_up_q;
  assign door_if.key_down  = key_down_q;
  assign door_if.door_open = (state_q == S_HOLD);
  assign door_if.busy      = in_travel(state_q);
  assign door_if.fault     = (state_q == S_FAULT);
  assign door_if.state_o   = state_q;

endmodule

// File: tb/tb_door_sequencer_ctrl.sv
// Randomized bench for door_sequencer_ctrl with a deadline-based reference model.
`timescale 1ns/1ps
module tb_door_sequencer_ctrl;
  import door_pkg::*;

  localparam int HOLD   = 8;
  localparam int TRAVEL = 16;
  localparam int W      = 8;

  // ---------------- clock / reset ----------------
  logic clk2m = 1'b0;
  logic rst_n = 1'b0;
  always #250 clk2m = ~clk2m;

  door_sequencer_ctrl_if dif();

  door_sequencer_ctrl #(
    .HOLD_CYC   (HOLD),
    .TRAVEL_CYC (TRAVEL),
    .CNT_W      (25)
  ) dut (
    .clk2m   (clk2m),
    .rst_n   (rst_n),
    .door_if (dif)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           checking = 1'b0;

  // Reference model: phase plus absolute deadline edge (no counter emulation).
  seq_state_t   m_st = S_IDLE;
  longint       m_deadline = 0;
  longint       edge_n = 0;

  function automatic logic [W-1:0] dut_out();
    return {dif.key_up, dif.key_down, dif.door_open, dif.busy, dif.fault, dif.state_o};
  endfunction

  function automatic logic p(int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%b expected=%b (ku kd open busy fault st[2:0])",
               name, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic co, cc, ob, fc, su, sd);
    logic ku, kd, expd;
    ku   = 1'b0;
    kd   = 1'b0;
    expd = (edge_n >= m_deadline);
    if (m_st != S_FAULT && su && sd) begin
      m_st = S_FAULT;
    end else begin
      case (m_st)
        S_IDLE, S_CLOSED:
          if (co) begin ku = 1'b1; m_deadline = edge_n + TRAVEL; m_st = S_WAIT_UP; end
        S_WAIT_UP:
          if (su) begin m_deadline = edge_n + HOLD; m_st = S_HOLD; end
          else if (expd) m_st = S_FAULT;
        S_HOLD: begin
`ifdef DOOR_AUTOCLOSE_EN
          if (co) m_deadline = edge_n + HOLD;
          else if (cc || (expd && !ob)) begin
            kd = 1'b1; m_deadline = edge_n + TRAVEL; m_st = S_WAIT_DOWN;
          end else if (expd) m_deadline = edge_n + HOLD;
`else
          if (cc && !co) begin kd = 1'b1; m_deadline = edge_n + TRAVEL; m_st = S_WAIT_DOWN; end
`endif
        end
        S_WAIT_DOWN:
          if (ob || co) begin
            ku = 1'b1; kd = 1'b1; m_deadline = edge_n + HOLD; m_st = S_HOLD;
          end else if (sd) m_st = S_CLOSED;
          else if (expd) m_st = S_FAULT;
        S_FAULT:
          if (fc) m_st = S_IDLE;
        default: m_st = S_IDLE;
      endcase
    end
    exp_q.push_back({ku, kd, m_st == S_HOLD, (m_st == S_WAIT_UP) || (m_st == S_WAIT_DOWN),
                     m_st == S_FAULT, 3'(m_st)});
    edge_n++;
  endtask

  // ---------------- driver tasks (entered and left on a falling edge) ----------------
  task automatic drive(input logic co, cc, ob, fc, su, sd);
    dif.cmd_open   = co;
    dif.cmd_close  = cc;
    dif.obstacle   = ob;
    dif.fault_clr  = fc;
    dif.sense_up   = su;
    dif.sense_down = sd;
    model_step(co, cc, ob, fc, su, sd);
    @(negedge clk2m);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic zero_inputs();
    dif.cmd_open   = 1'b0;
    dif.cmd_close  = 1'b0;
    dif.obstacle   = 1'b0;
    dif.fault_clr  = 1'b0;
    dif.sense_up   = 1'b0;
    dif.sense_down = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_async", dut_out(), '0);
    @(posedge clk2m);
    #1;
    check("reset_hold", dut_out(), '0);
    @(negedge clk2m);
    rst_n      = 1'b1;
    m_st       = S_IDLE;
    m_deadline = 0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk2m) begin
    #1;
    if (checking && rst_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL queue_underflow at %0t: got=%b expected=<none>", $time, dut_out());
      end else begin
        check("cycle_out", dut_out(), exp_q.pop_front());
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(64'd60_000 * 64'd500);
    n_err++;
    $display("FAIL watchdog: simulation time limit reached got=running required=done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    zero_inputs();
    repeat (3) @(negedge clk2m);
    check("reset_init", dut_out(), '0);
    rst_n      = 1'b1;
    m_st       = S_IDLE;
    m_deadline = 0;
    checking   = 1'b1;

    // Open, reach top, hold, then close.
    drive(1, 0, 0, 0, 0, 0);
    idle(4);
    drive(0, 0, 0, 0, 1, 0);
`ifdef DOOR_AUTOCLOSE_EN
    idle(10);
`else
    idle(100);
    drive(0, 1, 0, 0, 0, 0);
    idle(2);
`endif
    // Obstacle while closing reopens, then close properly.
    drive(0, 0, 1, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 0);
    idle(1);
    // Open and close together in S_CLOSED: open wins.
    drive(1, 1, 0, 0, 0, 0);
    idle(3);
    drive(0, 0, 0, 0, 1, 0);
    idle(1);
    // Both sensors in S_HOLD.
    drive(0, 0, 0, 0, 1, 1);
    idle(2);
    drive(0, 0, 0, 1, 0, 0);
    // Travel timeout.
    drive(1, 0, 0, 0, 0, 0);
    idle(20);
    drive(0, 0, 0, 1, 0, 0);
    // Reset mid-travel.
    drive(1, 0, 0, 0, 0, 0);
    idle(3);
    do_reset();

    for (int seg = 0; seg < 40; seg++) begin
      int prof;
      int len;
      prof = int'($urandom_range(0, 3));
      len  = int'($urandom_range(8, 50));
      if (prof == 3 && p(3)) do_reset();
      for (int c = 0; c < len; c++) begin
        drive(p(6), p(6), (prof == 2) ? p(3) : p(12), p(5),
              (prof == 1) ? 1'b0 : p(5), (prof == 1) ? 1'b0 : p(5));
      end
    end

    idle(2);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
